// File: rtl/mem_store_buffer.sv
// Store buffer between the memory stage and data memory: encodes sw/sh/sb into
// lane-placed data plus byte enables, queues them, optionally merges same-word stores.
module mem_store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int COALESCE   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [ADDR_WIDTH-1:0]         st_addr,
    input  logic [31:0]                   st_data,
    input  logic [1:0]                    st_size,
    output logic                          st_error,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [31:0]                   mem_data,
    output logic [3:0]                    mem_en,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [WW-1:0] ent_addr_q [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [3:0]    ent_mask_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          enc_ok;
    logic [31:0]   enc_data;
    logic [3:0]    enc_mask;
    logic [31:0]   merge_data;
    logic [PW-1:0] tail_ptr;
    logic          accept, do_merge, do_push, do_pop;

    // Lane k (mask bit k) is data byte [31-8k:24-8k]; unused lanes stay zero.
    always_comb begin
        enc_ok   = 1'b0;
        enc_data = '0;
        enc_mask = '0;
        case (st_size)
            2'b00: begin
                if (st_addr[1:0] == 2'b00) begin
                    enc_ok   = 1'b1;
                    enc_data = st_data;
                    enc_mask = 4'b1111;
                end
            end
            2'b01: begin
                if (!st_addr[0]) begin
                    enc_ok = 1'b1;
                    if (st_addr[1]) begin
                        enc_data = {16'b0, st_data[15:0]};
                        enc_mask = 4'b1100;
                    end else begin
                        enc_data = {st_data[15:0], 16'b0};
                        enc_mask = 4'b0011;
                    end
                end
            end
            2'b10: begin
                enc_ok   = 1'b1;
                enc_data = {st_data[7:0], 24'b0} >> {st_addr[1:0], 3'b000};
                enc_mask = 4'b0001 << st_addr[1:0];
            end
            default: ;
        endcase
    end

    assign st_ready = !rst && (count_q < DEPTH_C);
    assign accept   = st_valid && st_ready;
    assign tail_ptr = wr_ptr_q - PW'(1);
    assign do_pop   = mem_valid && mem_ready;

    // A count of 1 means the tail is the head being presented, so it is never merged.
    assign do_merge = accept && enc_ok && (COALESCE != 0) && (count_q >= TWO_C)
                      && (ent_addr_q[tail_ptr] == st_addr[ADDR_WIDTH-1:2]);
    assign do_push  = accept && enc_ok && !do_merge;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merge_data[31-8*gi -: 8] = enc_mask[gi] ? enc_data[31-8*gi -: 8]
                                                       : ent_data_q[tail_ptr][31-8*gi -: 8];
    end

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
        err_d = accept && !enc_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ent_mask_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            if (do_push) begin
                ent_addr_q[wr_ptr_q] <= st_addr[ADDR_WIDTH-1:2];
                ent_data_q[wr_ptr_q] <= enc_data;
                ent_mask_q[wr_ptr_q] <= enc_mask;
            end else if (do_merge) begin
                ent_data_q[tail_ptr] <= merge_data;
                ent_mask_q[tail_ptr] <= ent_mask_q[tail_ptr] | enc_mask;
            end
        end
    end

    assign mem_valid = (count_q != '0);
    assign empty     = !mem_valid;
    assign count     = count_q;
    assign st_error  = err_q;
    assign mem_addr  = mem_valid ? {ent_addr_q[rd_ptr_q], 2'b00} : '0;
    assign mem_data  = mem_valid ? ent_data_q[rd_ptr_q] : '0;
    assign mem_en    = mem_valid ? ent_mask_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based store model.
`timescale 1ns/1ps
module tb_mem_store_buffer;
    localparam int M_DEPTH = 4;
    localparam bit M_COAL  = 1'b1;

    logic        clk, rst, st_valid, st_ready, st_error, mem_valid, mem_ready, empty;
    logic [31:0] st_addr, st_data, mem_addr, mem_data;
    logic [1:0]  st_size;
    logic [3:0]  mem_en;
    logic [2:0]  count;

    mem_store_buffer #(.DEPTH(M_DEPTH), .ADDR_WIDTH(32), .COALESCE(1)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_error(st_error),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_en(mem_en), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what a store must look like on the memory side.
    function automatic void enc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                                output bit ok, output logic [31:0] data, output logic [3:0] m);
        int k;
        k = int'(a[1:0]);
        ok = 1'b0; data = '0; m = '0;
        if (s == 2'd0 && k == 0) begin
            ok = 1'b1; data = d; m = 4'hF;
        end else if (s == 2'd1 && (k % 2) == 0) begin
            ok = 1'b1; data = (d & 32'hFFFF) << (8 * (2 - k)); m = 4'b0011 << k;
        end else if (s == 2'd2) begin
            ok = 1'b1; data = (d & 32'hFF) << (8 * (3 - k)); m = 4'b0001 << k;
        end
    endfunction

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  m;
    } ent_t;
    ent_t q[$];
    bit   m_err = 1'b0;

    always @(posedge clk) begin : model
        bit          acc, pop, ok, merged;
        logic [31:0] ed;
        logic [3:0]  em;
        ent_t        t;
        if (rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            acc = st_valid && (q.size() < M_DEPTH);
            pop = (q.size() != 0) && mem_ready;
            enc(st_addr, st_data, st_size, ok, ed, em);
            m_err  = acc && !ok;
            merged = 1'b0;
            if (acc && ok && M_COAL && q.size() >= 2 && q[q.size()-1].w == st_addr[31:2]) begin
                t = q[q.size()-1];
                for (int b = 0; b < 4; b++)
                    if (em[b]) t.d[31-8*b -: 8] = ed[31-8*b -: 8];
                t.m = t.m | em;
                q[q.size()-1] = t;
                merged = 1'b1;
            end
            if (pop) void'(q.pop_front());
            if (acc && ok && !merged) begin
                t.w = st_addr[31:2]; t.d = ed; t.m = em;
                q.push_back(t);
            end
            if (acc)
                $display("store addr=%h size=%0d data=%h -> %s", st_addr, st_size, st_data,
                         !ok ? "error" : (merged ? "merged" : "queued"));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("st_ready", st_ready, !rst && q.size() < M_DEPTH);
            chk("st_error", st_error, m_err);
            chk("mem_valid", mem_valid, q.size() != 0);
            chk("empty", empty, q.size() == 0);
            chk("count", count, q.size());
            chk("mem_addr", mem_addr, q.size() != 0 ? {q[0].w, 2'b00} : 32'h0);
            chk("mem_data", mem_data, q.size() != 0 ? q[0].d : 32'h0);
            chk("mem_en", mem_en, q.size() != 0 ? q[0].m : 4'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
        step();
        st_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        st_valid = 1'b0;
        repeat (n) step();
    endtask

    logic [31:0] exp_b [4];
    logic [3:0]  exp_m [4];
    int          lvl;
    int          r;

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ready = 1'b0;
        exp_b = '{32'hAB000000, 32'h00AB0000, 32'h0000AB00, 32'h000000AB};
        exp_m = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        step(); step();
        chk_en = 1'b1;
        chk("rst count", count, 0);
        chk("rst mem_valid", mem_valid, 0);
        chk("rst st_ready", st_ready, 0);
        rst = 1'b0;
        #1;
        chk("post-rst st_ready", st_ready, 1);

        // Encoding sweep with immediate drain
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            store(32'h100 + k, 32'h123456AB, 2'd2);
            chk("sb data", mem_data, exp_b[k]);
            chk("sb en", mem_en, exp_m[k]);
            chk("sb addr", mem_addr, 32'h100);
        end
        store(32'h102, 32'hFFFF1234, 2'd1);
        chk("sh data", mem_data, 32'h00001234);
        chk("sh en", mem_en, 4'b1100);
        store(32'h104, 32'hDEADBEEF, 2'd0);
        chk("sw data", mem_data, 32'hDEADBEEF);
        chk("sw en", mem_en, 4'b1111);
        chk("sw addr", mem_addr, 32'h104);
        idle(1);

        // Error cases with one legal store in between
        mem_ready = 1'b0;
        store(32'h101, 32'h5555, 2'd1);
        chk("err sh st_error", st_error, 1);
        chk("err sh count", count, 0);
        store(32'h102, 32'h6666, 2'd0);
        chk("err sw st_error", st_error, 1);
        chk("err sw valid", mem_valid, 0);
        store(32'h010, 32'h77, 2'd2);
        chk("legal st_error", st_error, 0);
        chk("legal data", mem_data, 32'h77000000);
        store(32'h010, 32'h88, 2'd3);
        chk("err size st_error", st_error, 1);
        chk("err size count", count, 1);
        idle(1);
        chk("err pulse end", st_error, 0);
        mem_ready = 1'b1;
        idle(1);

        // Coalescing into the tail entry
        mem_ready = 1'b0;
        store(32'h200, 32'h11111111, 2'd0);
        store(32'h300, 32'hAA, 2'd2);
        store(32'h301, 32'hBB, 2'd2);
        chk("coal count", count, 2);
        chk("coal head", mem_data, 32'h11111111);
        mem_ready = 1'b1;
        idle(1);
        chk("coal tail addr", mem_addr, 32'h300);
        chk("coal tail data", mem_data, 32'hAABB0000);
        chk("coal tail en", mem_en, 4'b0011);
        idle(1);

        // Head is never merged
        mem_ready = 1'b0;
        store(32'h300, 32'h55, 2'd2);
        store(32'h301, 32'h66, 2'd2);
        chk("head count", count, 2);
        chk("head data", mem_data, 32'h55000000);
        chk("head en", mem_en, 4'b0001);
        mem_ready = 1'b1;
        idle(1);
        chk("head 2nd data", mem_data, 32'h00660000);
        idle(1);

        // Full and backpressure, then continuous traffic across pointer wrap
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'h400 + 4 * i, i, 2'd0);
        chk("full count", count, 4);
        chk("full st_ready", st_ready, 0);
        st_valid = 1'b1; st_addr = 32'h410; st_data = 32'h4; st_size = 2'd0;
        step();
        chk("full refuse", count, 4);
        mem_ready = 1'b1;
        step();
        chk("first pop st_ready", st_ready, 1);
        chk("first pop head", mem_addr, 32'h404);
        for (int j = 0; j < 8; j++) begin
            st_addr = 32'h414 + 4 * j; st_data = $urandom;
            step();
        end
        idle(6);
        chk("drained", count, 0);

        // Reset with entries queued
        mem_ready = 1'b0;
        store(32'h600, 32'h1, 2'd0);
        store(32'h604, 32'h2, 2'd0);
        store(32'h608, 32'h3, 2'd0);
        chk("pre-rst count", count, 3);
        rst = 1'b1;
        step();
        chk("rst mid valid", mem_valid, 0);
        chk("rst mid count", count, 0);
        chk("rst mid empty", empty, 1);
        chk("rst mid data", mem_data, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst mid st_ready", st_ready, 1);
        step();
        chk("rst mid no valid", mem_valid, 0);

        // Randomized traffic
        lvl = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) lvl = $urandom_range(0, 4);
            rst       = ($urandom_range(0, 299) == 0);
            st_valid  = ($urandom_range(0, 9) < 7);
            st_addr   = 32'h500 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            st_data   = $urandom;
            r         = $urandom_range(0, 9);
            st_size   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            mem_ready = ($urandom_range(0, 3) < lvl);
            step();
        end
        rst = 1'b0;
        mem_ready = 1'b1;
        idle(6);
        chk("final empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
